// File: rtl/pasc_output_queue.sv
// Output capture FIFO for the processor cluster: queues {core_id, data} words on
// output_enable and exposes them to a host through a small register port.
module pasc_output_queue #(
  parameter int DEPTH         = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int CORE_ID_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     output_enable,
  input  logic [CORE_ID_WIDTH-1:0] output_core_id,
  input  logic [DATA_WIDTH-1:0]    output_data_val,
  input  logic                     host_re,
  input  logic                     host_we,
  input  logic [1:0]               host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic [DATA_WIDTH-1:0]    host_rdata,
  output logic                     host_rvalid,
  output logic                     irq_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_TAG    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DROPS  = 2'd3;

  logic [DATA_WIDTH-1:0]    data_mem_q [DEPTH];
  logic [CORE_ID_WIDTH-1:0] id_mem_q   [DEPTH];

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] drop_count_q, drop_count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  irq_q, irq_d;

  logic       empty, full, pop, push, drop, wr_en;
  logic [4:0] count5;
  logic [7:0] status;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign count5 = 5'(count_q);
  assign status = {overflow_q, full, empty, count5};

  // A read and a write in the same cycle: the read wins, the write is dropped.
  assign wr_en = host_we & ~host_re;
  assign pop   = host_re & (host_addr == ADDR_DATA) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = output_enable & (~full | pop);
  assign drop  = output_enable & full & ~pop;

  always_comb begin
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    rdata_d      = rdata_q;
    rvalid_d     = host_re;
    irq_d        = (count_d != '0);

    if (wr_en && host_addr == ADDR_STATUS && host_wdata[7]) overflow_d = 1'b0;
    if (wr_en && host_addr == ADDR_DROPS) drop_count_d = '0;
    if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_count_d)) drop_count_d = drop_count_d + DATA_WIDTH'(1);
    end

    if (host_re) begin
      case (host_addr)
        ADDR_DATA:   rdata_d = empty ? '0 : data_mem_q[rd_ptr_q];
        ADDR_TAG:    rdata_d = empty ? '0 : DATA_WIDTH'(id_mem_q[rd_ptr_q]);
        ADDR_STATUS: rdata_d = DATA_WIDTH'(status);
        default:     rdata_d = drop_count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= output_data_val;
      id_mem_q[wr_ptr_q]   <= output_core_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      irq_q        <= irq_d;
    end
  end

  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;
  assign irq_pending = irq_q;

endmodule

// File: doc/pasc_output_queue.md
Name: pasc_output_queue

Overview:
- Downstream capture stage for the processor cluster's output port: samples every `output_enable` pulse and queues the `{core_id, data}` pair in a FIFO.
- Host drains the FIFO through a small register-mapped read/write port with 1-cycle registered read latency.
- Counts and flags words dropped on overflow, and raises a level interrupt while data is pending.
- Replaces direct console printing when the cluster runs on hardware.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..16.
- DATA_WIDTH, 16, width of output_data_val and host data bus.
- CORE_ID_WIDTH, 4, width of output_core_id.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- output_enable  input  1  cluster output strobe; one word per high cycle.
- output_core_id  input  CORE_ID_WIDTH  id of the core producing the word.
- output_data_val  input  DATA_WIDTH  output word.
- host_re  input  1  host read strobe.
- host_we  input  1  host write strobe.
- host_addr  input  2  register select.
- host_wdata  input  DATA_WIDTH  host write data.
- host_rdata  output  DATA_WIDTH  read data, valid the cycle after host_re.
- host_rvalid  output  1  high for one cycle with host_rdata.
- irq_pending  output  1  high while the FIFO is non-empty.

Behaviour:
- **Clock and reset:** one clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- **Reset values:** FIFO empty; rd_ptr = wr_ptr = 0; count = 0; overflow = 0; drop_count = 0; host_rdata = 0; host_rvalid = 0; irq_pending = 0.
- **Reset mid-operation:** discards all queued entries and any pending read response.
- **Push:**
  - Every cycle with output_enable = 1 pushes {output_core_id, output_data_val}.
  - If the FIFO is full and no pop happens that cycle, the word is dropped: overflow := 1, and drop_count increments, saturating at all-ones.
- **Pointers:** wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits; full = (count == DEPTH); empty = (count == 0).
- **Register map (host_addr):**
  - 0 DATA: read returns head data and pops. Read when empty returns 0 and leaves state unchanged.
  - 1 TAG: read returns head core_id zero-extended, no pop. Returns 0 when empty.
  - 2 STATUS: read returns {zeros, overflow[7], full[6], empty[5], count[4:0]}. Write with host_wdata[7] = 1 clears overflow.
  - 3 DROPS: read returns drop_count. Any write clears it to 0.
- **Read timing:**
  - host_re sampled at edge N; host_rdata and host_rvalid are registered and valid after edge N.
  - Head value, flags and count are those before edge N's updates.
  - host_rvalid deasserts the next cycle unless host_re is held.
  - Back-to-back DATA reads pop one entry per cycle.
- **Simultaneous events:**
  - host_re and host_we in the same cycle: the read is serviced and the write is ignored.
  - Push and pop in the same cycle, FIFO non-full: count unchanged, both take effect.
  - Push and pop in the same cycle, FIFO full: the pop frees a slot, the push is accepted, no drop.
  - Push and DATA read in the same cycle, FIFO empty: read returns 0, push is accepted, count becomes 1.
  - Drop and STATUS write clearing overflow in the same cycle: overflow ends at 1 (set wins).
  - Drop and DROPS write in the same cycle: drop_count ends at 1.
- **Interrupt:** irq_pending is registered from next-state count != 0, so it rises the cycle after the first push and falls the cycle after the last pop.
- **Ordering:** strict FIFO across all cores; no per-core reordering.

Test Plan:
- **Reset, then STATUS read:** rdata = 0x0020 (empty), irq_pending = 0; after reset_n is pulsed low mid-stream, STATUS again reads 0x0020.
- **Three words in, three DATA reads out:** push (core 2, 0x1234), (core 5, 0xBEEF), (core 0, 0x0001).
  - TAG read returns 0x0002.
  - Three DATA reads return 0x1234, 0xBEEF, 0x0001 in order.
  - STATUS then reads 0x0020 and irq_pending = 0.
- **Overflow:** push 18 words 0..17 with no reads.
  - STATUS reads 0x00D0 (overflow, full, count 16); DROPS reads 2.
  - Draining returns 0..15.
  - STATUS write 0x0080 clears overflow; DROPS write clears the counter to 0.
- **Push and pop at full:** with the FIFO full, push 0xAAAA and read DATA in the same cycle.
  - Returns the oldest word; count stays 16; DROPS unchanged.
  - The last word out after draining is 0xAAAA.
- **Empty read with push:** with the FIFO empty, push 0x5555 while reading DATA.
  - rdata = 0; the next DATA read returns 0x5555.
  - irq_pending is high for exactly the span between those reads.
- **Drop counter saturation:** force 65537 drops; DROPS reads 0xFFFF.
